// File: rtl/spike_packer.sv
// rtl/spike_packer.sv - packs per-group 4-bit spike bins into 16-bit words behind a small FIFO,
// and publishes a per-timestep active-group mask, a frame-done pulse and a timestep count.
module spike_packer #(
  parameter int CHANNELS   = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            spike_bin,
  input  logic                  valid_bin,
  input  logic                  active_group_out_bin,
  input  logic                  flush,
  input  logic                  clr_ovf,
  output logic [15:0]           o_word,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CHANNELS/4-1:0] o_active_mask,
  output logic                  o_frame_done,
  output logic [TS_W-1:0]       o_timestep,
  output logic                  o_overflow
);
  localparam int GROUPS = CHANNELS / 4;
  localparam int GW     = $clog2(GROUPS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  logic [1:0]        nib_cnt;
  logic [GW-1:0]     grp_cnt;
  logic [11:0]       shreg;
  logic [GROUPS-1:0] acc_mask;
  logic [GROUPS-1:0] mask_full;

  logic [16:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;

  logic beat, word_done, frame_end, pop, push, drop;

  // A flushed beat is discarded entirely, so it neither packs nor completes anything.
  always_comb begin
    beat      = valid_bin & ~flush;
    word_done = beat & (nib_cnt == 2'd3);
    frame_end = beat & (grp_cnt == LAST_GRP);
    o_valid   = (count != '0);
    pop       = o_valid & i_ready;
    push      = word_done & ((count < DEPTH_C) | pop);
    drop      = word_done & ~push;
    mask_full = acc_mask;
    mask_full[grp_cnt] = active_group_out_bin;
    o_word    = o_valid ? mem[rd_ptr][15:0] : 16'h0000;
    o_last    = o_valid ? mem[rd_ptr][16]   : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {(grp_cnt == LAST_GRP), spike_bin, shreg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nib_cnt       <= '0;
      grp_cnt       <= '0;
      shreg         <= '0;
      acc_mask      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      o_active_mask <= '0;
      o_frame_done  <= 1'b0;
      o_timestep    <= '0;
      o_overflow    <= 1'b0;
    end else begin
      o_frame_done <= frame_end;
      if (frame_end) begin
        o_active_mask <= mask_full;
        o_timestep    <= o_timestep + TS_W'(1);
      end
      if (drop)         o_overflow <= 1'b1;
      else if (clr_ovf) o_overflow <= 1'b0;

      if (flush) begin
        nib_cnt  <= '0;
        grp_cnt  <= '0;
        shreg    <= '0;
        acc_mask <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (beat) begin
          nib_cnt <= nib_cnt + 2'd1;
          case (nib_cnt)
            2'd0:    shreg[3:0]  <= spike_bin;
            2'd1:    shreg[7:4]  <= spike_bin;
            2'd2:    shreg[11:8] <= spike_bin;
            default: ;
          endcase
          if (frame_end) begin
            grp_cnt  <= '0;
            acc_mask <= '0;
          end else begin
            grp_cnt  <= grp_cnt + GW'(1);
            acc_mask <= mask_full;
          end
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_spike_packer.sv
// tb/tb_spike_packer.sv - scoreboard bench for spike_packer: a reference model predicts every
// FIFO word, mask, frame pulse, timestep and overflow, and checks the DUT each cycle.
module tb_spike_packer;
  localparam int G  = 32;
  localparam int D  = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    spike_bin = '0;
  logic          valid_bin = 1'b0;
  logic          active = 1'b0;
  logic          flush = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          i_ready = 1'b0;
  logic [15:0]   o_word;
  logic          o_last;
  logic          o_valid;
  logic [G-1:0]  o_active_mask;
  logic          o_frame_done;
  logic [TW-1:0] o_timestep;
  logic          o_overflow;

  always #5 clk = ~clk;

  spike_packer #(.CHANNELS(128), .FIFO_DEPTH(D), .TS_W(TW)) dut (
    .clk(clk), .rst(rst), .spike_bin(spike_bin), .valid_bin(valid_bin),
    .active_group_out_bin(active), .flush(flush), .clr_ovf(clr_ovf),
    .o_word(o_word), .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_active_mask(o_active_mask), .o_frame_done(o_frame_done),
    .o_timestep(o_timestep), .o_overflow(o_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state; updated at each falling edge for the coming rising edge.
  logic [16:0]   sb[$];
  logic [15:0]   got_w[$];
  logic [1:0]    m_nib;
  int            m_grp;
  logic [15:0]   m_sh;
  logic [G-1:0]  m_acc, m_mask;
  logic          m_fd, m_ovf, pop, ovf_set;
  logic [TW-1:0] m_ts;
  int            sz;

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      m_nib = '0; m_grp = 0; m_sh = '0; m_acc = '0; m_mask = '0;
      m_fd = 1'b0; m_ts = '0; m_ovf = 1'b0;
    end else begin
      check("o_valid", o_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        check("o_word", o_word, sb[0][15:0]);
        check("o_last", o_last, sb[0][16]);
      end
      check("o_active_mask", o_active_mask, m_mask);
      check("o_frame_done", o_frame_done, m_fd);
      check("o_timestep", o_timestep, m_ts);
      check("o_overflow", o_overflow, m_ovf);

      sz = sb.size();
      pop = (sz != 0) && i_ready;
      ovf_set = 1'b0;
      m_fd = 1'b0;
      if (pop) begin
        got_w.push_back(o_word);
        void'(sb.pop_front());
      end
      if (flush) begin
        sb.delete();
        m_nib = '0; m_grp = 0; m_sh = '0; m_acc = '0;
      end else if (valid_bin) begin
        if (m_nib == 2'd3) begin
          if (sz < D || pop) sb.push_back({m_grp == G - 1, spike_bin, m_sh[11:0]});
          else ovf_set = 1'b1;
        end else begin
          m_sh[4*m_nib +: 4] = spike_bin;
        end
        m_acc[m_grp] = active;
        if (m_grp == G - 1) begin
          m_mask = m_acc; m_acc = '0; m_fd = 1'b1; m_ts = m_ts + 1'b1; m_grp = 0;
        end else begin
          m_grp++;
        end
        m_nib = m_nib + 2'd1;
      end
      if (ovf_set)      m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic [3:0] b, input logic a);
    valid_bin = 1'b1; spike_bin = b; active = a;
    tick();
    valid_bin = 1'b0;
  endtask

  task automatic frame_pattern();
    for (int g = 0; g < G; g++) beat(g[3:0], g[0]);
  endtask

  task automatic frame_random();
    for (int g = 0; g < G; g++) beat(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_word"}, o_word, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_mask"}, o_active_mask, 0);
    check({tag, "_fd"}, o_frame_done, 0);
    check({tag, "_ts"}, o_timestep, 0);
    check({tag, "_ovf"}, o_overflow, 0);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    idle(2);
    rst = 1'b1;

    // Known pattern, consumer always ready.
    i_ready = 1'b1;
    got_w.delete();
    frame_pattern();
    idle(3);
    check("s1_nwords", got_w.size(), 8);
    if (got_w.size() == 8) begin
      check("s1_word0", got_w[0], 16'h3210);
      check("s1_word1", got_w[1], 16'h7654);
      check("s1_word7", got_w[7], 16'hFEDC);
    end
    check("s1_mask", o_active_mask, 32'hAAAAAAAA);
    check("s1_ts", o_timestep, 1);

    // Stalled consumer across three frames: overflow, then drain the oldest 8.
    i_ready = 1'b0;
    got_w.delete();
    repeat (3) frame_random();
    check("s2_ovf_set", o_overflow, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("s2_ovf_clr", o_overflow, 0);
    i_ready = 1'b1;
    idle(12);
    check("s2_drained", got_w.size(), 8);

    // Full FIFO, pop coincides with the completing beat.
    i_ready = 1'b0;
    frame_pattern();
    beat(4'h0, 1'b0); beat(4'h1, 1'b1); beat(4'h2, 1'b0);
    i_ready = 1'b1;
    beat(4'h3, 1'b1);
    i_ready = 1'b0;
    check("s3_ovf", o_overflow, 0);
    check("s3_valid", o_valid, 1);
    got_w.delete();
    i_ready = 1'b1;
    idle(12);
    check("s3_nwords", got_w.size(), 8);
    if (got_w.size() == 8) check("s3_newword", got_w[7], 16'h3210);

    // Flush mid-frame together with a beat.
    i_ready = 1'b0;
    for (int g = 4; g < 10; g++) beat(g[3:0], g[0]);
    flush = 1'b1; beat(4'hF, 1'b1); flush = 1'b0;
    check("s4_valid", o_valid, 0);
    i_ready = 1'b1;
    got_w.delete();
    frame_pattern();
    idle(3);
    check("s4_nwords", got_w.size(), 8);
    if (got_w.size() != 0) check("s4_word0", got_w[0], 16'h3210);
    check("s4_mask", o_active_mask, 32'hAAAAAAAA);

    // Asynchronous reset mid-word with data queued.
    i_ready = 1'b0;
    frame_pattern();
    beat(4'h5, 1'b1); beat(4'h6, 1'b1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b1;
    i_ready = 1'b1;
    got_w.delete();
    frame_pattern();
    idle(3);
    if (got_w.size() != 0) check("s5_word0", got_w[0], 16'h3210);
    else check("s5_nwords", 0, 8);

    // Timestep wrap from reset, then overflow beats a same-cycle clear.
    rst = 1'b0; tick(); rst = 1'b1;
    repeat (1 << TW) frame_pattern();
    idle(1);
    check("s6_ts_wrap0", o_timestep, 0);
    frame_pattern();
    idle(1);
    check("s6_ts_wrap1", o_timestep, 1);
    i_ready = 1'b0;
    frame_pattern();
    beat(4'h0, 1'b0); beat(4'h1, 1'b1); beat(4'h2, 1'b0);
    clr_ovf = 1'b1; beat(4'h3, 1'b1); clr_ovf = 1'b0;
    check("s6_ovf_wins", o_overflow, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("s6_ovf_clr", o_overflow, 0);
    i_ready = 1'b1;
    idle(12);
    check("final_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
